// File: rtl/ets_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ets_pkg
// Description : Shared types and constants for the ETS sweep sequencer.
//               Sweep FSM state encoding, default datapath widths and the
//               settle-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package ets_pkg;

  localparam int DEF_STEPS_W = 10;  // step count / phase index width
  localparam int DEF_DATA_W  = 32;  // accumulator count / tdata width
  localparam int SETTLE_W    = 8;   // settle time width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACQ    = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ABORT  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ets_axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : ets_axis_out_reg
// Description : Single-entry AXI-Stream output register. A load writes the
//               beat and raises tvalid on the next cycle; tvalid is held with
//               stable tdata/tlast until tready. A load may coincide with the
//               acceptance of the previous beat (back-to-back beats).
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               load            - write load_data/load_last into the register
//               load_data/last  - beat contents
//               tdata/tvalid/tlast/tready - AXI-Stream master side
//               full            - a beat is waiting for acceptance
// Revision    : 1.0 - initial release
// ============================================================================
module ets_axis_out_reg
  import ets_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast,
  output logic              full
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;

  // The caller only loads when the register is empty or being drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
      r_last  <= load_last;
    end else if (tready) begin
      r_valid <= 1'b0;
    end
  end

  assign tdata  = r_data;
  assign tvalid = r_valid;
  assign tlast  = r_last;
  assign full   = r_valid;

endmodule
`default_nettype wire

// File: rtl/ets_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ets_sweep_ctrl
// Description : Equivalent-time sweep sequencer. For each step it drives the
//               phase index, waits the settle time, runs one accumulator
//               acquisition (acc_start/acc_done) and emits the captured count
//               as one AXI-Stream beat, tlast on the final step.
// Ports       : clk, rst_n                 - clock, synchronous active-low reset
//               sweep_start, sweep_abort   - sweep control pulses
//               cfg_num_steps, cfg_settle  - sweep config, latched at start
//               phase                      - delay-tap select index
//               acc_start, acc_done, acc_data - accumulator handshake
//               m_axis_*                   - count output stream
//               busy, sweep_done           - status
// Revision    : 1.0 - initial release
// ============================================================================
module ets_sweep_ctrl
  import ets_pkg::*;
#(
  parameter int STEPS_W = DEF_STEPS_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sweep_start,
  input  logic                sweep_abort,
  input  logic [STEPS_W-1:0]  cfg_num_steps,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic [STEPS_W-1:0]  phase,
  output logic                acc_start,
  input  logic                acc_done,
  input  logic [DATA_W-1:0]   acc_data,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                sweep_done
);

  localparam logic [STEPS_W-1:0]  c_step_one   = STEPS_W'(1);
  localparam logic [SETTLE_W-1:0] c_settle_one = SETTLE_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [STEPS_W-1:0]  r_phase;
  logic [STEPS_W-1:0]  r_num_steps;
  logic [SETTLE_W-1:0] r_settle;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic                r_wait_done;    // ABORT still waiting for acc_done
  logic                r_empty_sweep;  // ABORT entered for a zero-step start
  logic                r_sweep_done;

  logic w_full;
  logic w_can_load;
  logic w_capture;
  logic w_last_step;
  logic w_settle_done;
  logic w_start_ok;
  logic w_start_zero;
  logic w_done_next;

  assign w_start_ok    = (r_state == ST_IDLE) && sweep_start && (cfg_num_steps != '0);
  assign w_start_zero  = (r_state == ST_IDLE) && sweep_start && (cfg_num_steps == '0);
  // Output register frees this cycle if empty or its beat is being accepted.
  assign w_can_load    = !w_full || m_axis_tready;
  assign w_last_step   = (r_phase == (r_num_steps - c_step_one));
  // A settle of 0 or 1 both give a single SETTLE cycle.
  assign w_settle_done = (r_settle <= c_settle_one) ||
                         (r_settle_cnt == (r_settle - c_settle_one));
  // Abort takes priority over a coincident acc_done.
  assign w_capture     = ((r_state == ST_ACQ) || (r_state == ST_HOLD)) &&
                         acc_done && !sweep_abort && w_can_load;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok)        w_next = ST_SETTLE;
        else if (w_start_zero) w_next = ST_ABORT;  // one busy cycle, no acquisition
      end
      ST_SETTLE: begin
        if (sweep_abort)        w_next = ST_IDLE;
        else if (w_settle_done) w_next = ST_ACQ;
      end
      ST_ACQ, ST_HOLD: begin
        if (sweep_abort)    w_next = ST_ABORT;
        else if (w_capture) w_next = w_last_step ? ST_IDLE : ST_SETTLE;
        else if (acc_done)  w_next = ST_HOLD;
      end
      ST_ABORT: begin
        if (!r_wait_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    acc_start = (r_state == ST_ACQ) || (r_state == ST_HOLD);
    busy      = (r_state != ST_IDLE);
  end

  // Zero-step sweeps report completion immediately; the IDLE entry that
  // follows their single ABORT cycle must not pulse a second time.
  assign w_done_next = w_start_zero ||
                       ((r_state != ST_IDLE) && (w_next == ST_IDLE) && !r_empty_sweep);

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase       <= '0;
      r_num_steps   <= '0;
      r_settle      <= '0;
      r_settle_cnt  <= '0;
      r_wait_done   <= 1'b0;
      r_empty_sweep <= 1'b0;
      r_sweep_done  <= 1'b0;
    end else begin
      r_sweep_done  <= w_done_next;
      r_empty_sweep <= w_start_zero;

      if (w_start_ok) begin
        r_num_steps  <= cfg_num_steps;
        r_settle     <= cfg_settle;
        r_phase      <= '0;
        r_settle_cnt <= '0;
      end else if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + c_settle_one;
      end else if (w_capture && !w_last_step) begin
        r_phase      <= r_phase + c_step_one;
        r_settle_cnt <= '0;
      end

      // An acquisition in flight must finish before IDLE; if acc_done is
      // already high on the aborting edge it counts as seen.
      if ((w_next == ST_ABORT) && (r_state != ST_ABORT))
        r_wait_done <= (r_state != ST_IDLE) && !acc_done;
      else if ((r_state == ST_ABORT) && acc_done)
        r_wait_done <= 1'b0;
    end
  end

  assign phase      = r_phase;
  assign sweep_done = r_sweep_done;

  ets_axis_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_capture),
    .load_data (acc_data),
    .load_last (w_last_step),
    .tdata     (m_axis_tdata),
    .tvalid    (m_axis_tvalid),
    .tready    (m_axis_tready),
    .tlast     (m_axis_tlast),
    .full      (w_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_ets_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ets_sweep_ctrl
// Description : Self-checking bench for ets_sweep_ctrl. A negedge environment
//               process models the accumulator and the stream sink and logs
//               what the DUT does; the main process runs table-driven,
//               hand-written and randomized sweeps and compares the logs with
//               expectations derived from the sweep rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ets_sweep_ctrl;
  import ets_pkg::*;

  localparam int STEPS_W = DEF_STEPS_W;
  localparam int DATA_W  = DEF_DATA_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sweep_start;
  logic                sweep_abort;
  logic [STEPS_W-1:0]  cfg_num_steps;
  logic [SETTLE_W-1:0] cfg_settle;
  logic [STEPS_W-1:0]  phase;
  logic                acc_start;
  logic                acc_done;
  logic [DATA_W-1:0]   acc_data;
  logic [DATA_W-1:0]   m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                m_axis_tlast;
  logic                busy;
  logic                sweep_done;

  always #5 clk = ~clk;

  ets_sweep_ctrl #(.STEPS_W(STEPS_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sweep_start   (sweep_start),
    .sweep_abort   (sweep_abort),
    .cfg_num_steps (cfg_num_steps),
    .cfg_settle    (cfg_settle),
    .phase         (phase),
    .acc_start     (acc_start),
    .acc_done      (acc_done),
    .acc_data      (acc_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .sweep_done    (sweep_done)
  );

  int    checks = 0;
  int    errors = 0;
  string cur_test = "init";

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got %0d, expected %0d", cur_test, name, act, exp);
    end
  endtask

  // ------------------------------------------------------- environment state
  int                cyc = 0;
  int                acc_lat = 1;
  logic [DATA_W-1:0] acc_vals[$];
  logic [DATA_W-1:0] issued[$];
  bit                acc_counting = 0;
  int                acc_cnt = 0;
  int                ready_mode = 0;   // 0: always ready, 1: random, 2: never
  bit                stall_armed = 0;
  int                stall_len = 0;
  int                stall_left = 0;
  logic [DATA_W-1:0] beat_data[$];
  bit                beat_last[$];
  int                rise_cyc[$];
  int                rise_phase[$];
  int                fall_cyc[$];
  int                done_cyc[$];
  int                start_cyc = 0;
  int                busy_cnt = 0;
  int                hold_cnt = 0;
  int                acc_done_cyc = 0;
  bit                pend = 0;
  logic [DATA_W-1:0] pend_data;
  bit                pend_last;
  bit                prev_acc_start = 0;

  // Accumulator model, stream sink and monitor, all acting on the negedge.
  initial begin
    acc_done      = 1'b0;
    acc_data      = '0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_left > 0) begin
        m_axis_tready = 1'b0;
        stall_left--;
      end else if (ready_mode == 0) m_axis_tready = 1'b1;
      else if (ready_mode == 1)     m_axis_tready = 1'($urandom_range(0, 1));
      else                          m_axis_tready = 1'b0;

      if (!rst_n) begin
        acc_done       = 1'b0;
        acc_counting   = 0;
        pend           = 0;
        prev_acc_start = 0;
      end else begin
        // accumulator: count acc_lat cycles, then hold done until start drops
        if (acc_done && !acc_start) acc_done = 1'b0;
        else if (acc_counting) begin
          if (acc_cnt <= 1) begin
            if (acc_vals.size() > 0) acc_data = acc_vals.pop_front();
            else                     acc_data = DATA_W'($urandom);
            issued.push_back(acc_data);
            acc_done     = 1'b1;
            acc_counting = 0;
            acc_done_cyc = cyc;
          end else acc_cnt--;
        end else if (acc_start && !acc_done) begin
          acc_counting = 1;
          acc_cnt      = acc_lat;
        end

        // a stalled beat must stay valid and stable
        if (pend) begin
          check("beat_held", m_axis_tvalid, 1);
          check("tdata_stable", m_axis_tdata, pend_data);
          check("tlast_stable", m_axis_tlast, pend_last);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beat_data.push_back(m_axis_tdata);
          beat_last.push_back(m_axis_tlast);
          pend = 0;
          if (stall_armed) begin
            stall_armed = 0;
            stall_left  = stall_len;
          end
        end else if (m_axis_tvalid) begin
          pend      = 1;
          pend_data = m_axis_tdata;
          pend_last = m_axis_tlast;
        end else pend = 0;

        if (acc_start && !prev_acc_start) begin
          rise_cyc.push_back(cyc);
          rise_phase.push_back(int'(phase));
        end
        if (!acc_start && prev_acc_start) fall_cyc.push_back(cyc);
        prev_acc_start = acc_start;
        if (sweep_start && !busy) start_cyc = cyc;
        if (sweep_done) done_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (acc_start && acc_done && m_axis_tvalid && !m_axis_tready) hold_cnt++;
      end
    end
  end

  // ------------------------------------------------------------------ tasks
  task automatic clear_logs();
    beat_data.delete(); beat_last.delete(); issued.delete(); acc_vals.delete();
    rise_cyc.delete(); rise_phase.delete(); fall_cyc.delete(); done_cyc.delete();
    busy_cnt = 0;
    hold_cnt = 0;
  endtask

  task automatic start_sweep(input int n, input int s);
    @(posedge clk); #1;
    cfg_num_steps = STEPS_W'(n);
    cfg_settle    = SETTLE_W'(s);
    sweep_start   = 1'b1;
    @(posedge clk); #1;
    sweep_start   = 1'b0;
    // config must have been latched; scramble it
    cfg_num_steps = STEPS_W'($urandom);
    cfg_settle    = SETTLE_W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (done_cyc.size() > 0) begin ok = 1; break; end
    end
    check("sweep_finished", ok, 1);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m_axis_tvalid && stall_left == 0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    check("output_drained", ok, 1);
  endtask

  task automatic run_sweep(input int n, input int s);
    start_sweep(n, s);
    wait_idle();
  endtask

  // Expected behaviour of a normal sweep of n steps.
  task automatic verify(input int n, input int exp_first, input int exp_gap);
    check("acq_count", issued.size(), n);
    check("beat_count", beat_data.size(), n);
    for (int i = 0; i < beat_data.size() && i < issued.size(); i++) begin
      check("beat_data", beat_data[i], issued[i]);
      check("beat_last", beat_last[i], (i == n - 1));
    end
    check("acq_start_count", rise_cyc.size(), n);
    for (int i = 0; i < rise_phase.size(); i++) check("phase_seq", rise_phase[i], i);
    if (rise_cyc.size() > 0) check("first_acc_start", rise_cyc[0] - start_cyc, exp_first);
    for (int i = 0; i + 1 < rise_cyc.size() && i < fall_cyc.size(); i++)
      check("settle_gap", rise_cyc[i+1] - fall_cyc[i], exp_gap);
    check("done_pulses", done_cyc.size(), 1);
    if (done_cyc.size() > 0 && fall_cyc.size() > 0)
      check("done_timing", done_cyc[0], fall_cyc[fall_cyc.size()-1]);
  endtask

  task automatic check_reset_outputs();
    check("rst_phase", phase, 0);
    check("rst_acc_start", acc_start, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
  endtask

  typedef struct {
    int steps;
    int settle;
    int lat;
    int rdy;
    int exp_first;  // cycles from start to first acc_start
    int exp_gap;    // acc_start low cycles between steps
  } vec_t;

  vec_t vecs[5];

  // ------------------------------------------------------------------- main
  initial begin
    bit found;
    int n, s, g;
    rst_n = 1'b0; sweep_start = 1'b0; sweep_abort = 1'b0;
    cfg_num_steps = '0; cfg_settle = '0;

    vecs[0] = '{4,    3, 1, 0, 4, 3};
    vecs[1] = '{2,    0, 2, 0, 2, 1};
    vecs[2] = '{3,    1, 3, 1, 2, 1};
    vecs[3] = '{1,    7, 2, 1, 8, 7};
    vecs[4] = '{1023, 0, 1, 0, 2, 1};

    cur_test = "reset";
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // four-step sweep with fixed counts
    cur_test = "basic";
    clear_logs();
    acc_lat = 2; ready_mode = 0;
    for (int i = 0; i < 4; i++) acc_vals.push_back(DATA_W'(10 * (i + 1)));
    run_sweep(4, 3);
    verify(4, 4, 3);
    for (int i = 0; i < beat_data.size(); i++) check("basic_value", beat_data[i], 10 * (i + 1));

    // table-driven sweeps
    for (int v = 0; v < 5; v++) begin
      cur_test = $sformatf("vec%0d", v);
      clear_logs();
      acc_lat = vecs[v].lat; ready_mode = vecs[v].rdy;
      run_sweep(vecs[v].steps, vecs[v].settle);
      verify(vecs[v].steps, vecs[v].exp_first, vecs[v].exp_gap);
    end

    // downstream stall of 50 cycles after the first beat forces HOLD
    cur_test = "stall";
    clear_logs();
    acc_lat = 2; ready_mode = 0; stall_len = 50; stall_armed = 1;
    for (int i = 0; i < 4; i++) acc_vals.push_back(DATA_W'(10 * (i + 1)));
    run_sweep(4, 3);
    verify(4, 4, 3);
    for (int i = 0; i < beat_data.size(); i++) check("stall_value", beat_data[i], 10 * (i + 1));
    check("hold_seen", hold_cnt > 0, 1);

    // zero-step start
    cur_test = "zero_steps";
    clear_logs();
    start_sweep(0, 3);
    repeat (5) @(posedge clk);
    #1;
    check("zero_acc_start", rise_cyc.size(), 0);
    check("zero_beats", beat_data.size(), 0);
    check("zero_done_pulses", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("zero_done_timing", done_cyc[0] - start_cyc, 1);
    check("zero_busy_cycles", busy_cnt, 1);

    // abort during the acquisition of step 2 of 5
    cur_test = "abort";
    clear_logs();
    acc_lat = 6; ready_mode = 0;
    start_sweep(5, 2);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (acc_start && phase == STEPS_W'(2)) begin found = 1; break; end
    end
    check("abort_reach_step2", found, 1);
    sweep_abort = 1'b1;
    @(posedge clk); #1;
    sweep_abort = 1'b0;
    check("abort_acc_start_low", acc_start, 0);
    check("abort_waits_busy", busy, 1);
    wait_idle();
    check("abort_beats", beat_data.size(), 2);
    check("abort_acqs", issued.size(), 3);
    for (int i = 0; i < beat_data.size() && i < issued.size(); i++) begin
      check("abort_beat_data", beat_data[i], issued[i]);
      check("abort_no_tlast", beat_last[i], 0);
    end
    check("abort_done_pulses", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("abort_done_timing", done_cyc[0] - acc_done_cyc, 2);

    cur_test = "after_abort";
    clear_logs();
    acc_lat = 2;
    run_sweep(2, 1);
    verify(2, 2, 1);

    // reset while in HOLD with a pending beat
    cur_test = "reset_hold";
    clear_logs();
    acc_lat = 1; ready_mode = 2;
    start_sweep(4, 1);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (acc_start && acc_done && m_axis_tvalid) begin found = 1; break; end
    end
    check("reached_hold", found, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (3) @(posedge clk);

    // randomized sweeps checked against the step rules
    for (int t = 0; t < 10; t++) begin
      cur_test = $sformatf("random%0d", t);
      clear_logs();
      n = $urandom_range(1, 8);
      s = $urandom_range(0, 5);
      acc_lat = $urandom_range(1, 4);
      ready_mode = 1;
      g = (s > 1) ? s : 1;
      run_sweep(n, s);
      verify(n, 1 + g, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ets_sweep_ctrl.md
# ets_sweep_ctrl

Sequencer directly upstream of the ETS accumulator in the StreamETS path. For each step of an equivalent-time sweep it drives a phase/tap index, waits a programmable settle time, runs one accumulator acquisition over the start/done handshake, and captures the 32-bit hit count. Each count is emitted as one AXI-Stream beat, with `tlast` on the final step of the sweep.

## Interface
- `STEPS_W`, 10: width of the step count and phase index.
- `DATA_W`, 32: accumulator count width and `tdata` width.

- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sweep_start`  in  1  one-cycle pulse; accepted only in IDLE.
- `sweep_abort`  in  1  one-cycle pulse; terminates the sweep.
- `cfg_num_steps`  in  STEPS_W  number of steps; latched on an accepted start.
- `cfg_settle`  in  8  idle cycles after each phase change; latched on an accepted start.
- `phase`  out  STEPS_W  current step index, fed to the delay-tap select.
- `acc_start`  out  1  level request to the accumulator.
- `acc_done`  in  1  accumulator result valid; held while `acc_start` is high.
- `acc_data`  in  DATA_W  accumulator count; valid while `acc_done` is high.
- `m_axis_tdata`  out  DATA_W  captured count.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  set on the last step's beat.
- `busy`  out  1  high in every state except IDLE.
- `sweep_done`  out  1  one-cycle pulse when a sweep completes or aborts.

## Operation
- States: IDLE, SETTLE, ACQ, HOLD, ABORT.
- IDLE
  - `sweep_start` with `cfg_num_steps` != 0: latch the config, set `phase` to 0, clear the settle counter, go to SETTLE.
  - `sweep_start` with `cfg_num_steps` == 0: no sweep; `sweep_done` pulses on the next cycle.
- SETTLE: count `cfg_settle` cycles, then go to ACQ. With `cfg_settle` == 0, SETTLE lasts exactly 1 cycle.
- ACQ: `acc_start` is high. On `acc_done`:
  - If the output register is empty, capture `acc_data` and the last-step flag.
  - If the output register is still full, go to HOLD.
- HOLD: `acc_start` stays high, so the accumulator holds `acc_done` and `acc_data` stable. Capture as soon as the output register frees, including in the same cycle it empties.
- After capture:
  - `acc_start` drops.
  - Not the last step: `phase` increments and the block enters SETTLE.
  - Last step: go to IDLE and pulse `sweep_done`.
- Output register
  - `tvalid` rises the cycle after capture and stays high until `tready`.
  - `tdata` and `tlast` are stable while `tvalid` is high.
  - A beat is never dropped, including on abort.
- Abort, in any non-IDLE state:
  - Drop `acc_start`. No further captures.
  - If an acquisition was started (ACQ or HOLD), wait in ABORT until `acc_done` has been seen high, plus one cycle. Otherwise go straight to IDLE.
  - `sweep_done` pulses on entry to IDLE.
  - No `tlast` is generated for an aborted sweep. A beat already pending still completes.
- `sweep_start` outside IDLE is ignored. `sweep_abort` in IDLE is ignored.
- Width rules:
  - `phase` counts 0..`cfg_num_steps`-1 and never wraps inside a sweep.
  - `cfg_num_steps` = 2^STEPS_W-1 is the maximum.
  - The count is passed through unmodified, with no arithmetic.

## Timing
- Reset values: `phase` 0, `acc_start` 0, `m_axis_tvalid` 0, `m_axis_tdata` 0, `m_axis_tlast` 0, `busy` 0, `sweep_done` 0, state IDLE.
- Reset mid-sweep: all outputs return to reset values on the next edge, and a pending beat is discarded. The accumulator is reset alongside this block.
- Start to first `acc_start`: 1 + max(`cfg_settle`, 1) cycles.
- `acc_done` to capture: same edge. `tvalid` and the next `phase` appear one cycle later.
- Between steps, `acc_start` is low for max(`cfg_settle`, 1) cycles, which is at least the accumulator's DONE→CLR→IDLE recovery time.
- Simultaneous events:
  - `acc_done` and `sweep_abort` in the same cycle: abort wins, no capture.
  - `tready` and a new capture in the same cycle: both occur, giving back-to-back beats.

## Structure
- Shared package `ets_pkg`: state enum, default `STEPS_W`/`DATA_W`, and the settle-counter width constant.
- Sub-module `ets_axis_out_reg`: single-entry output register with a valid/ready handshake and a `full` flag exported to the FSM.
- FSM, phase counter and settle counter stay in the top module.

## Test plan
- `cfg_num_steps`=4, `cfg_settle`=3, `tready` tied high, accumulator model returns 10, 20, 30, 40 → four beats in order, `tlast` only on 40, `phase` sequence 0,1,2,3, one `sweep_done` pulse.
- Same sweep with `tready` low for 50 cycles after the first beat → HOLD entered with `acc_start` held high, no beat lost or duplicated, `tdata` stable while stalled.
- `cfg_num_steps`=0 → no `acc_start`, no beat, `sweep_done` one cycle after start, `busy` high for 1 cycle.
- `sweep_abort` during ACQ of step 2 of 5 → ABORT waits for `acc_done`, the step-2 count is not emitted, no `tlast`, `sweep_done` pulses, and the next `sweep_start` runs normally.
- `rst_n` low for 1 cycle mid-HOLD with `tvalid` high → all outputs return to reset values the next cycle, `phase`=0.
- `cfg_settle`=0 with 2 steps → `acc_start` low for exactly 1 cycle between acquisitions.
